// File: rtl/idu_pipe_if.sv
// rtl/idu_pipe_if.sv - fetch-side and execute-side handshake bundle of the decode stage
interface idu_pipe_if #(
    parameter int XLEN           = 32,
    parameter int REG_ADDR_WIDTH = 5
);
    logic                      in_valid;
    logic                      in_ready;
    logic [31:0]               in_inst;
    logic [XLEN-1:0]           in_pc;
    logic                      out_valid;
    logic                      out_ready;
    logic [XLEN-1:0]           out_pc;
    logic [3:0]                out_class;
    logic [2:0]                out_type;
    logic [REG_ADDR_WIDTH-1:0] out_rd;
    logic [REG_ADDR_WIDTH-1:0] out_rs1;
    logic [REG_ADDR_WIDTH-1:0] out_rs2;
    logic [2:0]                out_funct3;
    logic                      out_funct7b5;
    logic [XLEN-1:0]           out_imm;
    logic                      out_rd_we;
    logic                      out_illegal;

    modport master (
        output in_valid, in_inst, in_pc, out_ready,
        input  in_ready, out_valid, out_pc, out_class, out_type, out_rd, out_rs1, out_rs2,
               out_funct3, out_funct7b5, out_imm, out_rd_we, out_illegal
    );

    modport slave (
        input  in_valid, in_inst, in_pc, out_ready,
        output in_ready, out_valid, out_pc, out_class, out_type, out_rd, out_rs1, out_rs2,
               out_funct3, out_funct7b5, out_imm, out_rd_we, out_illegal
    );
endinterface

// File: rtl/idu_pipe.sv
// rtl/idu_pipe.sv - registered RV32I/RV64I decode stage with 2-entry skid buffer
module idu_pipe #(
    parameter int XLEN           = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int CNT_WIDTH      = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    idu_pipe_if.slave            io,
    output logic [CNT_WIDTH-1:0] dec_cnt
);
    localparam bit RV64 = (XLEN == 64);

    localparam logic [3:0] C_INV = 4'd0, C_LUI = 4'd1, C_AUIPC = 4'd2, C_JAL = 4'd3,
                           C_JALR = 4'd4, C_BRANCH = 4'd5, C_LOAD = 4'd6, C_STORE = 4'd7,
                           C_OPIMM = 4'd8, C_OP = 4'd9, C_SYSTEM = 4'd10, C_FENCE = 4'd11;
    localparam logic [2:0] T_N = 3'd0, T_R = 3'd1, T_I = 3'd2, T_S = 3'd3,
                           T_B = 3'd4, T_U = 3'd5, T_J = 3'd6;

    typedef struct packed {
        logic [XLEN-1:0]           pc;
        logic [3:0]                cls;
        logic [2:0]                typ;
        logic [REG_ADDR_WIDTH-1:0] rd;
        logic [REG_ADDR_WIDTH-1:0] rs1;
        logic [REG_ADDR_WIDTH-1:0] rs2;
        logic [2:0]                funct3;
        logic                      funct7b5;
        logic [XLEN-1:0]           imm;
        logic                      rd_we;
        logic                      illegal;
    } entry_t;

    entry_t          dec, main_q, skid_q;
    logic            main_valid, skid_valid, accept, drain;
    logic [31:0]     inst;
    logic [6:0]      opcode, f7;
    logic [2:0]      f3;
    logic            bad, sh_zero, sh_sra;
    logic [3:0]      cls;
    logic [2:0]      typ;
    logic [XLEN-1:0] imm, imm_i, imm_s, imm_b, imm_u, imm_j;

    assign inst   = io.in_inst;
    assign opcode = inst[6:0];
    assign f3     = inst[14:12];
    assign f7     = inst[31:25];

    assign imm_i = XLEN'($signed(inst[31:20]));
    assign imm_s = XLEN'($signed({inst[31:25], inst[11:7]}));
    assign imm_b = XLEN'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
    assign imm_u = XLEN'($signed({inst[31:12], 12'b0}));
    assign imm_j = XLEN'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));

    // shamt is one bit wider on RV64, so the funct7-like field above it shrinks
    assign sh_zero = RV64 ? (inst[31:26] == 6'b000000) : (inst[31:25] == 7'b0000000);
    assign sh_sra  = RV64 ? (inst[31:26] == 6'b010000) : (inst[31:25] == 7'b0100000);

    always_comb begin
        cls = C_INV;
        typ = T_N;
        bad = 1'b0;
        case (opcode)
            7'b0110111: begin cls = C_LUI;    typ = T_U; end
            7'b0010111: begin cls = C_AUIPC;  typ = T_U; end
            7'b1101111: begin cls = C_JAL;    typ = T_J; end
            7'b1100111: begin cls = C_JALR;   typ = T_I; bad = (f3 != 3'b000); end
            7'b1100011: begin cls = C_BRANCH; typ = T_B; bad = (f3 == 3'b010) || (f3 == 3'b011); end
            7'b0000011: begin
                cls = C_LOAD; typ = T_I;
                bad = (f3 == 3'b111) || (!RV64 && ((f3 == 3'b011) || (f3 == 3'b110)));
            end
            7'b0100011: begin cls = C_STORE; typ = T_S; bad = f3[2] || (!RV64 && (f3 == 3'b011)); end
            7'b0010011: begin
                cls = C_OPIMM; typ = T_I;
                if (f3 == 3'b001)      bad = !sh_zero;
                else if (f3 == 3'b101) bad = !(sh_zero || sh_sra);
            end
            7'b0110011: begin
                cls = C_OP; typ = T_R;
                bad = !((f7 == 7'b0000000) ||
                        ((f7 == 7'b0100000) && ((f3 == 3'b000) || (f3 == 3'b101))));
            end
            7'b1110011: begin
                cls = C_SYSTEM; typ = T_I;
                bad = (inst != 32'h0000_0073) && (inst != 32'h0010_0073);
            end
            7'b0001111: begin cls = C_FENCE; typ = T_I; end
            default:    bad = 1'b1;
        endcase
        if (bad) begin
            cls = C_INV;
            typ = T_N;
        end
    end

    always_comb begin
        imm = '0;
        case (typ)
            T_I:     imm = imm_i;
            T_S:     imm = imm_s;
            T_B:     imm = imm_b;
            T_U:     imm = imm_u;
            T_J:     imm = imm_j;
            default: imm = '0;
        endcase
    end

    always_comb begin
        dec          = '0;
        dec.pc       = io.in_pc;
        dec.cls      = cls;
        dec.typ      = typ;
        dec.rd       = REG_ADDR_WIDTH'(inst[11:7]);
        dec.rs1      = REG_ADDR_WIDTH'(inst[19:15]);
        dec.rs2      = REG_ADDR_WIDTH'(inst[24:20]);
        dec.funct3   = f3;
        dec.funct7b5 = inst[30];
        dec.imm      = imm;
        dec.rd_we    = (cls inside {C_LUI, C_AUIPC, C_JAL, C_JALR, C_LOAD, C_OPIMM, C_OP}) &&
                       (inst[11:7] != 5'd0);
        dec.illegal  = bad;
    end

    assign accept = io.in_valid && !skid_valid;
    assign drain  = !main_valid || io.out_ready;

    // skid only fills while main is stalled, so skid_valid implies main_valid
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            main_q     <= '0;
            skid_q     <= '0;
            dec_cnt    <= '0;
        end else if (flush) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else begin
            if (accept) dec_cnt <= dec_cnt + CNT_WIDTH'(1);
            if (drain) begin
                if (skid_valid) begin
                    main_q     <= skid_q;
                    main_valid <= 1'b1;
                    skid_valid <= 1'b0;
                end else begin
                    main_valid <= accept;
                    if (accept) main_q <= dec;
                end
            end else if (accept) begin
                skid_q     <= dec;
                skid_valid <= 1'b1;
            end
        end
    end

    assign io.in_ready     = !skid_valid;
    assign io.out_valid    = main_valid;
    assign io.out_pc       = main_q.pc;
    assign io.out_class    = main_q.cls;
    assign io.out_type     = main_q.typ;
    assign io.out_rd       = main_q.rd;
    assign io.out_rs1      = main_q.rs1;
    assign io.out_rs2      = main_q.rs2;
    assign io.out_funct3   = main_q.funct3;
    assign io.out_funct7b5 = main_q.funct7b5;
    assign io.out_imm      = main_q.imm;
    assign io.out_rd_we    = main_q.rd_we;
    assign io.out_illegal  = main_q.illegal;
endmodule

// File: tb/tb_idu_pipe.sv
// tb/tb_idu_pipe.sv - scoreboard bench driving RV32 and RV64 decode stages in lockstep
module tb_idu_pipe;
    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic [31:0] cnt32;
    logic [3:0]  cnt64;

    always #5 clk = ~clk;

    idu_pipe_if #(.XLEN(32), .REG_ADDR_WIDTH(5)) b32 ();
    idu_pipe_if #(.XLEN(64), .REG_ADDR_WIDTH(5)) b64 ();

    idu_pipe #(.XLEN(32), .REG_ADDR_WIDTH(5), .CNT_WIDTH(32)) dut32 (
        .clk(clk), .rst(rst), .flush(flush), .io(b32), .dec_cnt(cnt32)
    );
    idu_pipe #(.XLEN(64), .REG_ADDR_WIDTH(5), .CNT_WIDTH(4)) dut64 (
        .clk(clk), .rst(rst), .flush(flush), .io(b64), .dec_cnt(cnt64)
    );

    typedef struct packed {
        logic [63:0] pc;
        logic [3:0]  cls;
        logic [2:0]  typ;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic        f7b5;
        logic [63:0] imm;
        logic        rd_we;
        logic        ill;
    } exp_t;

    exp_t        q32[$];
    exp_t        q64[$];
    int          errors = 0;
    int          checks = 0;
    int          n_acc = 0;
    bit          mon_en = 1'b0;
    bit          acc_p = 1'b0;
    bit          fl_p = 1'b0;
    logic [31:0] ai;
    logic [63:0] ap;

    // Reference decoder: legality from funct3 masks, immediates from bit arithmetic.
    function automatic exp_t ref_dec(input logic [31:0] i, input logic [63:0] pc, input bit rv64);
        exp_t        e;
        int          cls, typ, sw;
        bit          ok;
        logic [7:0]  m;
        logic [11:0] hi;
        logic [31:0] sx, v;
        cls = 0; typ = 0; ok = 1'b1;
        case (i[6:0])
            7'h37: begin cls = 1; typ = 5; end
            7'h17: begin cls = 2; typ = 5; end
            7'h6F: begin cls = 3; typ = 6; end
            7'h67: begin cls = 4; typ = 2; ok = (i[14:12] == 3'd0); end
            7'h63: begin cls = 5; typ = 4; m = 8'hF3; ok = m[i[14:12]]; end
            7'h03: begin cls = 6; typ = 2; m = rv64 ? 8'h7F : 8'h37; ok = m[i[14:12]]; end
            7'h23: begin cls = 7; typ = 3; m = rv64 ? 8'h0F : 8'h07; ok = m[i[14:12]]; end
            7'h13: begin
                cls = 8; typ = 2;
                if (i[14:12] == 3'd1 || i[14:12] == 3'd5) begin
                    sw = rv64 ? 6 : 5;
                    hi = i[31:20] >> sw;
                    ok = (hi == 12'd0) || (i[14:12] == 3'd5 && hi == (12'h400 >> sw));
                end
            end
            7'h33: begin
                cls = 9; typ = 1;
                ok = (i[31:25] == 7'h00) ||
                     (i[31:25] == 7'h20 && (i[14:12] == 3'd0 || i[14:12] == 3'd5));
            end
            7'h73: begin cls = 10; typ = 2; ok = (i == 32'h73) || (i == 32'h0010_0073); end
            7'h0F: begin cls = 11; typ = 2; end
            default: ok = 1'b0;
        endcase
        if (!ok) begin cls = 0; typ = 0; end
        sx = {32{i[31]}};
        case (typ)
            2:       v = (sx << 12) | 32'(i[31:20]);
            3:       v = (sx << 12) | 32'({i[31:25], i[11:7]});
            4:       v = (sx << 12) | (32'(i[7]) << 11) | (32'(i[30:25]) << 5) | (32'(i[11:8]) << 1);
            5:       v = i & 32'hFFFF_F000;
            6:       v = (sx << 20) | (32'(i[19:12]) << 12) | (32'(i[20]) << 11) | (32'(i[30:21]) << 1);
            default: v = 32'd0;
        endcase
        e.pc    = pc;
        e.cls   = 4'(cls);
        e.typ   = 3'(typ);
        e.rd    = i[11:7];
        e.rs1   = i[19:15];
        e.rs2   = i[24:20];
        e.f3    = i[14:12];
        e.f7b5  = i[30];
        e.imm   = {{32{v[31]}}, v};
        e.rd_we = (cls inside {1, 2, 3, 4, 6, 8, 9}) && (i[11:7] != 5'd0);
        e.ill   = !ok;
        return e;
    endfunction

    function automatic logic [31:0] rand_inst();
        logic [31:0] w;
        logic [6:0]  ops[11];
        ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h73, 7'h0F};
        w = $urandom;
        if ($urandom_range(0, 9) != 0) w[6:0] = ops[$urandom_range(0, 10)];
        if ($urandom_range(0, 1) != 0) w[31:25] = ($urandom_range(0, 1) != 0) ? 7'h00 : 7'h20;
        if (w[6:0] == 7'h73 && $urandom_range(0, 2) != 0)
            w = ($urandom_range(0, 1) != 0) ? 32'h73 : 32'h0010_0073;
        return w;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic chk_e(input string nm, input exp_t act, input exp_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got pc=%h cls=%0d imm=%h ill=%b raw=%h expected pc=%h cls=%0d imm=%h ill=%b raw=%h",
                     nm, act.pc, act.cls, act.imm, act.ill, act, exp.pc, exp.cls, exp.imm, exp.ill, exp);
        end
    endtask

    // One cycle: commit last cycle's handshake to the model, then drive new inputs.
    task automatic step(input bit v, input logic [31:0] inst, input logic [63:0] pc,
                        input bit ordy, input bit fl);
        @(posedge clk);
        if (fl_p) begin
            q32.delete();
            q64.delete();
        end else if (acc_p) begin
            q32.push_back(ref_dec(ai, ap, 1'b0));
            q64.push_back(ref_dec(ai, ap, 1'b1));
            n_acc++;
        end
        #1;
        b32.in_valid = v;   b64.in_valid = v;
        b32.in_inst = inst; b64.in_inst = inst;
        b32.in_pc = pc[31:0]; b64.in_pc = pc;
        b32.out_ready = ordy; b64.out_ready = ordy;
        flush = fl;
        acc_p = v && (q32.size() < 2);
        fl_p  = fl;
        ai    = inst;
        ap    = pc;
    endtask

    always @(negedge clk) begin
        exp_t act, e;
        if (mon_en) begin
            chk("in_ready32", 64'(b32.in_ready), 64'(q32.size() < 2));
            chk("in_ready64", 64'(b64.in_ready), 64'(q64.size() < 2));
            chk("out_valid32", 64'(b32.out_valid), 64'(q32.size() > 0));
            chk("out_valid64", 64'(b64.out_valid), 64'(q64.size() > 0));
            chk("dec_cnt32", 64'(cnt32), 64'(n_acc[31:0]));
            chk("dec_cnt64", 64'(cnt64), 64'(n_acc[3:0]));
            if (b32.out_valid && q32.size() > 0) begin
                act = {32'd0, b32.out_pc, b32.out_class, b32.out_type, b32.out_rd, b32.out_rs1,
                       b32.out_rs2, b32.out_funct3, b32.out_funct7b5, 32'd0, b32.out_imm,
                       b32.out_rd_we, b32.out_illegal};
                e = q32[0];
                e.pc[63:32]  = '0;
                e.imm[63:32] = '0;
                chk_e("entry32", act, e);
                if (b32.out_ready) void'(q32.pop_front());
            end
            if (b64.out_valid && q64.size() > 0) begin
                act = {b64.out_pc, b64.out_class, b64.out_type, b64.out_rd, b64.out_rs1,
                       b64.out_rs2, b64.out_funct3, b64.out_funct7b5, b64.out_imm,
                       b64.out_rd_we, b64.out_illegal};
                chk_e("entry64", act, q64[0]);
                if (b64.out_ready) void'(q64.pop_front());
            end
        end
    end

    initial begin
        logic [31:0] ills[3];
        ills = '{32'hFFFF_FFFF, 32'h4000_1033, 32'h0020_0073};
        rst = 1'b1; flush = 1'b0;
        b32.in_valid = 0; b32.in_inst = 0; b32.in_pc = 0; b32.out_ready = 0;
        b64.in_valid = 0; b64.in_inst = 0; b64.in_pc = 0; b64.out_ready = 0;
        #12;
        chk("rst_out_valid", 64'(b32.out_valid), 64'd0);
        chk("rst_dec_cnt", 64'(cnt32), 64'd0);
        chk("rst_out_imm", 64'(b64.out_imm), 64'd0);
        chk("rst_out_pc", 64'(b32.out_pc), 64'd0);
        @(negedge clk) rst = 1'b0;
        mon_en = 1'b1;

        // addi x1,x0,5
        step(1, 32'h0050_0093, 64'h8000_0000, 1, 0);
        step(0, 0, 0, 1, 0);
        @(negedge clk);
        chk("addi_class", 64'(b32.out_class), 64'd8);
        chk("addi_type", 64'(b32.out_type), 64'd2);
        chk("addi_rd", 64'(b32.out_rd), 64'd1);
        chk("addi_imm", 64'(b32.out_imm), 64'd5);
        chk("addi_rd_we", 64'(b32.out_rd_we), 64'd1);
        chk("addi_cnt", 64'(cnt32), 64'd1);

        // sw / beq / lui with downstream stalled
        step(1, 32'h0020_A423, 64'h8000_0004, 0, 0);
        step(1, 32'hFE00_0EE3, 64'h8000_0008, 0, 0);
        step(1, 32'h1234_52B7, 64'h8000_000C, 0, 0);
        @(negedge clk);
        chk("stall_in_ready", 64'(b32.in_ready), 64'd0);
        chk("stall_class", 64'(b32.out_class), 64'd7);
        chk("stall_imm", 64'(b32.out_imm), 64'd8);
        chk("stall_rd_we", 64'(b32.out_rd_we), 64'd0);
        step(1, 32'h1234_52B7, 64'h8000_000C, 1, 0);
        step(1, 32'h1234_52B7, 64'h8000_000C, 1, 0);
        @(negedge clk);
        chk("beq_imm", 64'(b32.out_imm), 64'hFFFF_FFFC);
        step(0, 0, 0, 1, 0);
        @(negedge clk);
        chk("lui_imm", 64'(b32.out_imm), 64'h1234_5000);

        // flush together with an ebreak accept while an entry is held
        step(1, 32'h0050_0093, 64'h8000_0010, 0, 0);
        step(1, 32'h0010_0073, 64'h8000_0014, 0, 1);
        step(0, 0, 0, 1, 0);
        @(negedge clk);
        chk("flush_out_valid", 64'(b32.out_valid), 64'd0);
        chk("flush_in_ready", 64'(b32.in_ready), 64'd1);
        chk("flush_cnt", 64'(cnt32), 64'd5);

        for (int k = 0; k < 3; k++) begin
            step(1, ills[k], 64'h100 + 64'(k), 1, 0);
            step(0, 0, 0, 1, 0);
            @(negedge clk);
            chk("ill_flag", 64'(b32.out_illegal), 64'd1);
            chk("ill_class", 64'(b32.out_class), 64'd0);
            chk("ill_rd_we", 64'(b32.out_rd_we), 64'd0);
        end

        // lui x5,0x80000 sign-extends on RV64
        step(1, 32'h8000_02B7, 64'hFFFF_0000_0000_1000, 1, 0);
        step(0, 0, 0, 1, 0);
        @(negedge clk);
        chk("lui64_imm", b64.out_imm, 64'hFFFF_FFFF_8000_0000);
        chk("lui32_imm", 64'(b32.out_imm), 64'h8000_0000);

        for (int k = 0; k < 16; k++) step(1, 32'h0050_0093, 64'(k * 4), 1, 0);
        step(0, 0, 0, 1, 0);
        @(negedge clk);
        chk("wrap_cnt64", 64'(cnt64), 64'd9);
        chk("wrap_cnt32", 64'(cnt32), 64'd25);

        for (int k = 0; k < 3000; k++)
            step($urandom_range(0, 3) != 0, rand_inst(), {$urandom, $urandom},
                 $urandom_range(0, 9) < 7, $urandom_range(0, 31) == 0);
        for (int k = 0; k < 4; k++) step(0, 0, 0, 1, 0);
        @(negedge clk);
        chk("drained", 64'(q32.size() + q64.size()), 64'd0);

        // asynchronous reset while an entry is presented
        step(1, 32'h0050_0093, 64'h40, 0, 0);
        step(0, 0, 0, 0, 0);
        @(negedge clk);
        mon_en = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("arst_out_valid", 64'(b32.out_valid), 64'd0);
        chk("arst_cnt32", 64'(cnt32), 64'd0);
        chk("arst_cnt64", 64'(cnt64), 64'd0);
        chk("arst_out_pc", 64'(b64.out_pc), 64'd0);
        q32.delete(); q64.delete();
        n_acc = 0; acc_p = 1'b0; fl_p = 1'b0;
        @(negedge clk) rst = 1'b0;
        mon_en = 1'b1;
        step(0, 0, 0, 1, 0);
        @(negedge clk);
        chk("arst_in_ready", 64'(b32.in_ready), 64'd1);
        step(0, 0, 0, 1, 0);
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
